mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
//  Bus responder on the far end of the CPU datapath's Addressbus/Databus. Services CPU memory
//  read/write requests with a fixed wait-state count and memDataReady handshake. Backed by an
//  internal synchronous RAM; addresses >= IO_BASE map to an output latch and an input port
//  feeding the datapath's IO data path.
// PARAMETERS
//  DATA_W       16       data bus width
//  ADDR_W       16       address bus width
//  MEM_AW       10       RAM index width (depth = 2**MEM_AW words)
//  WAIT_CYCLES  2        wait states between request accept and memDataReady (>=0)
//  IO_BASE      16'hFF00 first IO-mapped address; [IO_BASE, 2**ADDR_W-1] is IO space
// PORTS
//  clk            in   1       clock, all logic on rising edge
//  rst            in   1       synchronous reset, active-high
//  Addressbus     in   ADDR_W  request address from datapath
//  wdata          in   DATA_W  write data from datapath (ALU output)
//  readMem        in   1       read request, level, held until memDataReady seen
//  writeMem       in   1       write request, level, held until memDataReady seen
//  Databus        out  DATA_W  read data to datapath/IR
//  memDataReady   out  1       one-cycle completion pulse
//  bus_err        out  1       one-cycle pulse on protocol violation
//  io_in          in   DATA_W  external input port value
//  io_out         out  DATA_W  IO output latch
//  io_out_stb     out  1       one-cycle pulse when io_out updated
// BEHAVIOUR
//  Reset: state=IDLE; Databus=0, memDataReady=0, bus_err=0, io_out=0, io_out_stb=0,
//   wait counter=0. RAM contents NOT cleared. Reset mid-transaction aborts it (no write).
//  FSM: IDLE -> WAIT -> RESP -> HOLD -> IDLE.
//  IDLE: exactly one of readMem/writeMem high -> latch Addressbus, wdata, op; counter=0;
//   go WAIT (WAIT_CYCLES=0 -> go RESP directly). Both high -> bus_err=1 next cycle, stay IDLE,
//   no access.
//  WAIT: counter++ each cycle; at counter==WAIT_CYCLES-1 go RESP. Request dropped (latched
//   op's line low) -> abort to IDLE, no write, no memDataReady.
//  RESP (1 cycle): memDataReady=1. Read: Databus = RAM[addr[MEM_AW-1:0]] or io_in (sampled in
//   this cycle) when addr>=IO_BASE. Write: RAM updated at this edge, or io_out=wdata and
//   io_out_stb=1 for IO address. Databus unchanged on writes. -> HOLD.
//  HOLD: wait until readMem and writeMem both low, then IDLE. Prevents double service of a
//   held level request. Databus keeps last read value until next read RESP.
//  Latency: request high in cycle T (IDLE) -> memDataReady high in cycle T+1+WAIT_CYCLES.
//  Address mapping: non-IO addresses alias modulo 2**MEM_AW (upper bits ignored).
//  Latched address/data used throughout; changes on Addressbus/wdata after accept ignored.
//  Back-to-back: new request accepted only from IDLE; min spacing = WAIT_CYCLES+3 cycles.
// TESTING
//  1 rst; write 16'h1234 to 16'h0005, deassert on ready -> memDataReady in cycle T+3
//    (WAIT_CYCLES=2); read 16'h0005 -> Databus=16'h1234.
//  2 Alias: write 16'hBEEF to 16'h0405 (MEM_AW=10), read 16'h0005 -> 16'hBEEF.
//  3 IO: write 16'h00A5 to 16'hFF10 -> io_out=16'h00A5, io_out_stb one cycle, RAM unchanged;
//    io_in=16'h5A5A, read 16'hFF00 -> Databus=16'h5A5A.
//  4 readMem and writeMem high together -> bus_err one cycle, no memDataReady, RAM unchanged.
//  5 writeMem dropped during WAIT -> no memDataReady, later read shows old data; rst asserted
//    in WAIT -> IDLE, outputs zero, RAM intact.
//  6 readMem held high 10 cycles -> exactly one memDataReady pulse; WAIT_CYCLES=0 build ->
//    memDataReady in cycle T+1.

Source files
------------

// File: rtl/mem_io_responder.sv
`default_nettype none
//============================================================================
// Module   : mem_io_responder
// Purpose  : Bus responder for the CPU datapath. Services level-held
//            read/write requests after a fixed number of wait states and
//            signals completion with a one-cycle memDataReady pulse.
//            Addresses below IO_BASE hit an internal synchronous RAM; addresses
//            at or above IO_BASE hit an output latch (writes) or the io_in
//            port (reads).
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
// Ports
//   clk           in   1       clock, rising edge
//   rst           in   1       synchronous reset, active-high
//   Addressbus    in   ADDR_W  request address
//   wdata         in   DATA_W  write data
//   readMem       in   1       read request (level, held until ready)
//   writeMem      in   1       write request (level, held until ready)
//   Databus       out  DATA_W  read data, holds last read value
//   memDataReady  out  1       one-cycle completion pulse
//   bus_err       out  1       pulse when read and write requested together
//   io_in         in   DATA_W  external input port
//   io_out        out  DATA_W  IO output latch
//   io_out_stb    out  1       one-cycle pulse when io_out is written
//============================================================================
module mem_io_responder #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                MEM_AW      = 10,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] IO_BASE     = 16'hFF00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addressbus,
    input  logic [DATA_W-1:0] wdata,
    input  logic              readMem,
    input  logic              writeMem,
    output logic [DATA_W-1:0] Databus,
    output logic              memDataReady,
    output logic              bus_err,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_out_stb
);

    localparam int DEPTH = 1 << MEM_AW;
    // Counter runs 0 .. WAIT_CYCLES-1 while in WAIT.
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              op_write_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              req_one;
    logic              req_both;
    logic              op_line;
    logic              fire;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_write;
    logic              acc_io;
    logic [MEM_AW-1:0] acc_idx;

    // "fire" marks the clock edge that moves the FSM into RESP. The access is
    // performed on that edge so that Databus / io_out are already valid in
    // the same cycle memDataReady is high. With zero wait states the access
    // happens straight out of IDLE, so the live bus values are used instead
    // of the (not yet loaded) latches.
    always_comb begin
        req_one  = readMem ^ writeMem;
        req_both = readMem & writeMem;
        op_line  = op_write_q ? writeMem : readMem;

        if (state == S_IDLE) begin
            acc_addr  = Addressbus;
            acc_wdata = wdata;
            acc_write = writeMem;
        end else begin
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_write = op_write_q;
        end

        acc_io  = (acc_addr >= IO_BASE);
        acc_idx = acc_addr[MEM_AW-1:0];

        case (state)
            S_IDLE:  fire = req_one && (WAIT_CYCLES == 0);
            S_WAIT:  fire = op_line && (cnt == CNT_LAST);
            default: fire = 1'b0;
        endcase
    end

    // RAM has no reset; contents survive rst. A reset edge suppresses the
    // write so an interrupted transaction leaves memory untouched.
    always_ff @(posedge clk) begin
        if (!rst && fire && acc_write && !acc_io) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_write_q   <= 1'b0;
            Databus      <= '0;
            memDataReady <= 1'b0;
            bus_err      <= 1'b0;
            io_out       <= '0;
            io_out_stb   <= 1'b0;
        end else begin
            memDataReady <= 1'b0;
            bus_err      <= 1'b0;
            io_out_stb   <= 1'b0;

            if (fire) begin
                memDataReady <= 1'b1;
                if (acc_write) begin
                    if (acc_io) begin
                        io_out     <= acc_wdata;
                        io_out_stb <= 1'b1;
                    end
                end else begin
                    Databus <= acc_io ? io_in : mem[acc_idx];
                end
            end

            case (state)
                S_IDLE: begin
                    if (req_both) begin
                        bus_err <= 1'b1;
                    end else if (req_one) begin
                        addr_q     <= Addressbus;
                        wdata_q    <= wdata;
                        op_write_q <= writeMem;
                        cnt        <= '0;
                        state      <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Requester gave up: abandon silently.
                    if (!op_line) begin
                        state <= S_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    // Requests are level signals; wait for release so one
                    // held request is never serviced twice.
                    if (!readMem && !writeMem) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
//============================================================================
// Module   : tb_mem_io_responder
// Purpose  : Self-checking bench for mem_io_responder. Stimulus pushes the
//            expected responses into queues; a monitor pops and compares
//            whenever the DUT raises memDataReady / io_out_stb / bus_err.
//            A second instance with zero wait states checks the short path.
// Revision : 1.0  initial release
//============================================================================
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addressbus, wdata, io_in;
    logic        readMem, writeMem;
    logic [15:0] Databus, io_out;
    logic        memDataReady, bus_err, io_out_stb;

    logic [15:0] addr0, wd0, db0, ioo0;
    logic        rm0, wm0, rdy0, berr0, stb0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic        is_read;
        logic [15:0] data;
    } resp_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } io_t;

    resp_t resp_q[$];
    io_t   io_q[$];
    int    berr_q[$];

    mem_io_responder #(.WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .Addressbus(Addressbus), .wdata(wdata),
        .readMem(readMem), .writeMem(writeMem), .Databus(Databus),
        .memDataReady(memDataReady), .bus_err(bus_err), .io_in(io_in),
        .io_out(io_out), .io_out_stb(io_out_stb)
    );

    mem_io_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .Addressbus(addr0), .wdata(wd0),
        .readMem(rm0), .writeMem(wm0), .Databus(db0),
        .memDataReady(rdy0), .bus_err(berr0), .io_in(io_in),
        .io_out(ioo0), .io_out_stb(stb0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every DUT response against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (memDataReady) begin
                if (resp_q.size() == 0) begin
                    check("ready_unexpected", 32'd1, 32'd0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("ready_cycle", cyc, r.cyc);
                    if (r.is_read) check("read_data", {16'h0, Databus}, {16'h0, r.data});
                end
            end
            if (io_out_stb) begin
                if (io_q.size() == 0) begin
                    check("io_stb_unexpected", 32'd1, 32'd0);
                end else begin
                    io_t e;
                    e = io_q.pop_front();
                    check("io_stb_cycle", cyc, e.cyc);
                    check("io_out_value", {16'h0, io_out}, {16'h0, e.data});
                end
            end
            if (bus_err) begin
                if (berr_q.size() == 0) begin
                    check("bus_err_unexpected", 32'd1, 32'd0);
                end else begin
                    check("bus_err_cycle", cyc, berr_q.pop_front());
                end
            end
        end
    end

    task automatic wait_ready();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (memDataReady) seen = 1;
        end
        if (!seen) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        Addressbus = a; wdata = d; writeMem = 1'b1;
        resp_q.push_back('{cyc + 3, 1'b0, 16'h0});
        if (a >= 16'hFF00) io_q.push_back('{cyc + 3, d});
        wait_ready();
        @(posedge clk); #1;
        writeMem = 1'b0;
        Addressbus = 16'h0000; wdata = 16'h0000;
        @(posedge clk);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] exp);
        @(posedge clk); #1;
        Addressbus = a; readMem = 1'b1;
        resp_q.push_back('{cyc + 3, 1'b1, exp});
        wait_ready();
        @(posedge clk); #1;
        readMem = 1'b0;
        Addressbus = 16'h0000;
        @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        Addressbus = '0; wdata = '0; readMem = 0; writeMem = 0; io_in = '0;
        addr0 = '0; wd0 = '0; rm0 = 0; wm0 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_Databus", {16'h0, Databus}, 32'h0);
        check("rst_ready", {31'h0, memDataReady}, 32'h0);
        check("rst_bus_err", {31'h0, bus_err}, 32'h0);
        check("rst_io_out", {16'h0, io_out}, 32'h0);
        check("rst_io_stb", {31'h0, io_out_stb}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: basic write / read back
        do_write(16'h0005, 16'h1234);
        do_read(16'h0005, 16'h1234);

        // 2: alias modulo 1024 words
        do_write(16'h0405, 16'hBEEF);
        do_read(16'h0005, 16'hBEEF);

        // 3: IO space; RAM index 0x310 must not be touched by write to FF10
        do_write(16'h0310, 16'h1111);
        do_write(16'hFF10, 16'h00A5);
        check("io_out_latched", {16'h0, io_out}, 32'h00A5);
        do_read(16'h0310, 16'h1111);
        io_in = 16'h5A5A;
        do_read(16'hFF00, 16'h5A5A);
        // writes leave Databus alone
        do_write(16'h0020, 16'h2020);
        check("databus_kept_on_write", {16'h0, Databus}, 32'h5A5A);

        // 4: read and write together -> bus_err, no access
        @(posedge clk); #1;
        Addressbus = 16'h0005; wdata = 16'hDEAD; readMem = 1; writeMem = 1;
        berr_q.push_back(cyc + 1);
        @(posedge clk); #1;
        readMem = 0; writeMem = 0;
        repeat (6) @(posedge clk);
        do_read(16'h0005, 16'hBEEF);

        // 5a: write dropped during WAIT -> abandoned
        @(posedge clk); #1;
        Addressbus = 16'h0005; wdata = 16'h7777; writeMem = 1;
        @(posedge clk); #1;
        writeMem = 0;
        repeat (6) @(posedge clk);
        do_read(16'h0005, 16'hBEEF);

        // 5b: reset during WAIT -> aborted, outputs cleared, RAM intact
        @(posedge clk); #1;
        Addressbus = 16'h0005; wdata = 16'h9999; writeMem = 1;
        @(posedge clk); #1;
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_Databus", {16'h0, Databus}, 32'h0);
        check("midrst_io_out", {16'h0, io_out}, 32'h0);
        check("midrst_ready", {31'h0, memDataReady}, 32'h0);
        @(posedge clk); #1;
        writeMem = 0; rst = 0;
        repeat (2) @(posedge clk);
        do_read(16'h0005, 16'hBEEF);

        // 6: read held for 10 cycles -> exactly one response
        @(posedge clk); #1;
        Addressbus = 16'h0005; readMem = 1;
        resp_q.push_back('{cyc + 3, 1'b1, 16'hBEEF});
        repeat (10) @(posedge clk);
        #1 readMem = 0;
        repeat (4) @(posedge clk);

        // 6b: zero-wait-state build answers in cycle T+1
        @(posedge clk); #1;
        addr0 = 16'h0042; wd0 = 16'h4242; wm0 = 1;
        @(negedge clk);
        check("wc0_wr_ready_T", {31'h0, rdy0}, 32'h0);
        @(negedge clk);
        check("wc0_wr_ready_T1", {31'h0, rdy0}, 32'h1);
        @(posedge clk); #1 wm0 = 0;
        repeat (2) @(posedge clk);
        #1 rm0 = 1;
        @(negedge clk);
        check("wc0_rd_ready_T", {31'h0, rdy0}, 32'h0);
        @(negedge clk);
        check("wc0_rd_ready_T1", {31'h0, rdy0}, 32'h1);
        check("wc0_rd_data", {16'h0, db0}, 32'h4242);
        @(posedge clk); #1 rm0 = 0;
        @(negedge clk);
        check("wc0_ready_pulse", {31'h0, rdy0}, 32'h0);

        repeat (5) @(posedge clk);
        check("resp_q_drained", resp_q.size(), 32'd0);
        check("io_q_drained", io_q.size(), 32'd0);
        check("berr_q_drained", berr_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
